tx_pkt_arb_2: RTL and testbench
===============================

Name: tx_pkt_arb_2

Overview:
- Packet-granular 2-source transmit arbiter that sits directly downstream of the 2-way round-robin grant logic in the optimized TX path.
- Presents per-source pending requests to the RR arbiter and pulses its enable to request a decision.
- Latches the one-hot grant and locks the output mux onto the granted source until that source's last beat is accepted.
- Valid/ready streaming on both sides; no data storage beyond the grant lock.

Parameters:
DATA_W, 64, width of the data beat
CNT_W, 16, width of the optional per-source packet counters

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
s0_valid  in  1  source 0 beat valid
s0_data  in  DATA_W  source 0 beat data
s0_last  in  1  source 0 last beat of packet
s0_ready  out  1  source 0 beat accepted when high with s0_valid
s1_valid  in  1  source 1 beat valid
s1_data  in  DATA_W  source 1 beat data
s1_last  in  1  source 1 last beat of packet
s1_ready  out  1  source 1 beat accepted when high with s1_valid
arb_req  out  2  request vector to RR arbiter, {s1_valid, s0_valid} while IDLE, else 0
arb_ena  out  1  RR decision strobe; arbiter updates its history on this cycle
arb_grant  in  2  one-hot combinational grant from RR arbiter
m_valid  out  1  output beat valid
m_data  out  DATA_W  output beat data
m_last  out  1  output last beat
m_ready  in  1  downstream accepts beat
busy  out  1  high while locked to a source
sel  out  1  locked source index (0/1), meaningful while busy

Behaviour:
- Reset: state IDLE, sel=0, busy=0; m_valid, s0_ready, s1_ready, arb_ena=0; arb_req follows the inputs combinationally (0 if no source valid).
- The interface uses one clock; reset is asynchronous and active-high on sys_rst. All registers clear on sys_rst assertion, without waiting for a clock edge.
- State IDLE:
  - arb_req={s1_valid,s0_valid}; arb_ena=|arb_req (combinational).
  - m_valid=0; both source readies 0.
  - On a clock edge with arb_ena=1: sel<=arb_grant[1] and state<=BUSY.
  - arb_grant must be one-hot when arb_ena=1. A zero or 2'b11 grant is a protocol error: stay IDLE, flag it in simulation only.
- State BUSY:
  - arb_req=0; arb_ena=0.
  - m_valid/m_data/m_last come from source sel, combinationally.
  - Only s<sel>_ready=m_ready; the other source ready is 0.
  - A beat transfers when m_valid&&m_ready.
  - A transfer with m_last=1 returns state to IDLE on that edge.
- Latency:
  - First beat of a packet appears on m_valid one cycle after the source raises valid in IDLE.
  - One IDLE bubble cycle separates consecutive packets, including back-to-back packets from the same source.
- Fairness:
  - Both sources continuously valid gives alternating packets 0,1,0,1…, as decided by the RR history, which advances once per packet.
  - Single-beat packets (valid+last together) are legal: one IDLE cycle + one BUSY cycle.
- Source valid may drop mid-packet (gap). The block stays BUSY on sel with m_valid=0, and never re-arbitrates before the last beat.
- The non-selected source may assert valid at any time. It is stalled (ready=0) and must hold data per the valid/ready rule.
- Reset mid-packet: immediately IDLE. The partial packet is abandoned; downstream must tolerate a truncated packet after reset.
- The block adds no registers on the data path.

Optional Feature:
- Macro TX_PKT_ARB_STATS_EN.
- Defined:
  - Adds outputs pkt_cnt0 and pkt_cnt1 (CNT_W each).
  - Each increments by 1 on a transfer of a last beat from that source.
  - Counters wrap from all-ones to 0 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold sys_rst with s0_valid=1. Require m_valid=0, arb_ena=1, busy=0. Release sys_rst; next edge gives busy=1, sel=0.
- Single source: source 0 sends a 3-beat packet D0..D2, m_ready=1. Require m_data D0,D1,D2 on consecutive cycles starting 1 cycle after s0_valid, m_last on D2, IDLE the following cycle.
- Contention: both sources continuously offer 2-beat packets. Require output packet order 0,1,0,1, one bubble between packets, and s1_ready=0 throughout source-0 packets.
- Backpressure/gap: during a source-1 packet, toggle m_ready 1,0,0,1 and drop s1_valid for 2 cycles mid-packet. Require no beat loss or duplication, sel stays 1, and no arb_ena pulse until after the last beat.
- Reset mid-packet: assert sys_rst after beat 1 of 4. Require m_valid=0 and busy=0 immediately, asynchronously. After release, the next arbitration works normally.
- Stats (TX_PKT_ARB_STATS_EN): preload by sending 2^CNT_W−1 source-0 packets (use CNT_W=4, so 15), then one more. Require pkt_cnt0 to go 15→0 while pkt_cnt1 stays unchanged.

Source files
------------

// File: rtl/tx_pkt_arb_2.sv
// Packet-granular 2-source TX arbiter: asks an external RR arbiter for a decision, locks onto the grant until last beat.
// Optional per-source packet counters: define TX_PKT_ARB_STATS_EN.
module tx_pkt_arb_2 #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [1:0]        arb_req,
  output logic              arb_ena,
  input  logic [1:0]        arb_grant,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              sel
`ifdef TX_PKT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

  // Handshake: a beat moves on any edge where valid && ready; valid never waits on ready.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_nxt;
  logic   sel_q, sel_nxt;
  logic   grant_ok;
  logic   last_xfer;

  assign grant_ok  = (arb_grant == 2'b01) || (arb_grant == 2'b10);
  assign last_xfer = m_valid && m_ready && m_last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    arb_req   = 2'b00;
    arb_ena   = 1'b0;
    m_valid   = 1'b0;
    m_data    = sel_q ? s1_data : s0_data;
    m_last    = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    case (state)
      IDLE: begin
        arb_req = {s1_valid, s0_valid};
        arb_ena = s0_valid | s1_valid;
        // A malformed grant leaves us IDLE; the request simply repeats next cycle.
        if (arb_ena && grant_ok) begin
          state_nxt = BUSY;
          sel_nxt   = arb_grant[1];
        end
      end
      BUSY: begin
        if (sel_q) begin
          m_valid  = s1_valid;
          m_last   = s1_last;
          s1_ready = m_ready;
        end else begin
          m_valid  = s0_valid;
          m_last   = s0_last;
          s0_ready = m_ready;
        end
        if (m_valid && m_ready && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign sel  = sel_q;

  // The RR arbiter must hand back exactly one grant bit whenever it is strobed.
  grant_onehot_a: assert property (@(posedge sys_clk) disable iff (sys_rst)
    arb_ena |-> grant_ok);

`ifdef TX_PKT_ARB_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (last_xfer) begin
      if (sel_q) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      else       pkt_cnt0 <= pkt_cnt0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_pkt_arb_2.sv
// Bench for tx_pkt_arb_2: RR arbiter environment, randomized sources, per-cycle reference model and directed pins.
module tb_tx_pkt_arb_2;
  localparam int DATA_W = 64;
`ifdef TX_PKT_ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              s0_valid, s0_last, s0_ready;
  logic [DATA_W-1:0] s0_data;
  logic              s1_valid, s1_last, s1_ready;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        arb_req, arb_grant;
  logic              arb_ena;
  logic              m_valid, m_last, m_ready;
  logic [DATA_W-1:0] m_data;
  logic              busy, sel;
`ifdef TX_PKT_ARB_STATS_EN
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
`endif

  tx_pkt_arb_2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .arb_req(arb_req), .arb_ena(arb_ena), .arb_grant(arb_grant),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .sel(sel)
`ifdef TX_PKT_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RR arbiter environment ----------------
  logic rr_last;
  always_comb begin
    if (arb_req == 2'b11) arb_grant = rr_last ? 2'b01 : 2'b10;
    else                  arb_grant = arb_req;
  end
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      rr_last <= 1'b1;
    else if (arb_ena) rr_last <= arb_grant[1];
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model: IDLE asks for a decision, RR between simultaneous requests, lock until last beat.
  logic              mbusy = 1'b0, msel = 1'b0, mrr = 1'b1;
  logic [31:0]       exp_q[$];
  int                out_src_q[$];
  int                out_cyc_q[$];
  logic [CNT_W-1:0]  mcnt[2] = '{default: '0};

  always @(negedge sys_clk) begin
    logic [1:0]        v;
    logic              g, sv, sl;
    logic [DATA_W-1:0] sd;
    v = {s1_valid, s0_valid};
    if (sys_rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {s1_ready, s0_ready}, 0);
      chk("rst_arb_ena", arb_ena, |v);
`ifdef TX_PKT_ARB_STATS_EN
      chk("rst_cnt0", pkt_cnt0, 0);
      chk("rst_cnt1", pkt_cnt1, 0);
`endif
      mbusy = 1'b0; msel = 1'b0; mrr = 1'b1;
      mcnt[0] = '0; mcnt[1] = '0;
      exp_q.delete();
    end else begin
`ifdef TX_PKT_ARB_STATS_EN
      chk("pkt_cnt0", pkt_cnt0, mcnt[0]);
      chk("pkt_cnt1", pkt_cnt1, mcnt[1]);
`endif
      if (!mbusy) begin
        chk("idle_arb_req", arb_req, v);
        chk("idle_arb_ena", arb_ena, |v);
        chk("idle_m_valid", m_valid, 0);
        chk("idle_ready", {s1_ready, s0_ready}, 0);
        chk("idle_busy", busy, 0);
        if (|v) begin
          g = (v == 2'b11) ? !mrr : v[1];
          mbusy = 1'b1; msel = g; mrr = g;
          exp_q.push_back(g ? s1_data[63:32] : s0_data[63:32]);
        end
      end else begin
        sv = msel ? s1_valid : s0_valid;
        sd = msel ? s1_data  : s0_data;
        sl = msel ? s1_last  : s0_last;
        chk("busy_arb_req", arb_req, 0);
        chk("busy_arb_ena", arb_ena, 0);
        chk("busy", busy, 1);
        chk("sel", sel, msel);
        chk("m_valid", m_valid, sv);
        chk("m_data", m_data, sd);
        chk("m_last", m_last, sl);
        chk("s_ready", {s1_ready, s0_ready}, msel ? {m_ready, 1'b0} : {1'b0, m_ready});
        if (sv && m_ready && sl) begin
          if (exp_q.size() == 0) chk("pkt_order_empty", 1, 0);
          else                   chk("pkt_order", m_data[63:32], exp_q.pop_front());
          mcnt[msel] = mcnt[msel] + 1'b1;
          out_src_q.push_back(int'(msel));
          out_cyc_q.push_back(cyc);
          mbusy = 1'b0;
        end
      end
    end
  end

  // ---------------- source / sink driver ----------------
  logic vld[2];
  int   len[2], beat[2], pkt[2], pv[2];
  bit   en[2], acc[2];
  int   pr, len_min, len_max;

  function automatic logic [DATA_W-1:0] data_of(input int s);
    return {8'(s), 24'(pkt[s]), 32'(beat[s])};
  endfunction

  task automatic apply();
    s0_valid = vld[0]; s0_data = data_of(0); s0_last = (beat[0] == len[0] - 1);
    s1_valid = vld[1]; s1_data = data_of(1); s1_last = (beat[1] == len[1] - 1);
  endtask

  task automatic cycle();
    @(negedge sys_clk);
    acc[0] = s0_valid && s0_ready;
    acc[1] = s1_valid && s1_ready;
    @(posedge sys_clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) begin
        if (beat[s] == len[s] - 1) begin
          pkt[s]++; beat[s] = 0; len[s] = $urandom_range(len_min, len_max);
        end else beat[s]++;
      end
      // A pending beat is held until taken; a packet already started keeps going even if disabled.
      vld[s] = (vld[s] && !acc[s]) ||
               ((en[s] || beat[s] != 0) && ($urandom_range(0, 99) < pv[s]));
    end
    m_ready = ($urandom_range(0, 99) < pr);
    apply();
  endtask

  task automatic set_len(input int n);
    len_min = n; len_max = n;
    for (int s = 0; s < 2; s++) if (beat[s] == 0) len[s] = n;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    en[0] = 1'b0; en[1] = 1'b0; pv[0] = 100; pv[1] = 100; pr = 100;
    for (int i = 0; i < 60 && !done; i++) begin
      cycle();
      done = !busy && !vld[0] && !vld[1] && beat[0] == 0 && beat[1] == 0;
    end
    chk("drain_done", done, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  int exp_order[4] = '{1, 0, 1, 0};
  int pr_pat[10]   = '{100, 100, 0, 0, 100, 100, 100, 100, 100, 100};
  int pv1_pat[10]  = '{100, 100, 100, 100, 100, 0, 0, 100, 100, 100};
  int nb;

  initial begin
    sys_rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; beat[s] = 0; pkt[s] = 0; len[s] = 3; pv[s] = 100; en[s] = 1'b0;
    end
    len_min = 3; len_max = 3; pr = 100; m_ready = 1'b1;
    en[0] = 1'b1; vld[0] = 1'b1;
    apply();

    // Reset held with s0 requesting
    #6;
    chk("t1_m_valid", m_valid, 0);
    chk("t1_arb_ena", arb_ena, 1);
    chk("t1_busy", busy, 0);
    chk("t1_arb_req", arb_req, 2'b01);
    cycle();
    sys_rst = 1'b0;
    #1;
    chk("t1_idle_after_release", busy, 0);

    // Single source, 3-beat packet D0..D2
    cycle(); #1;
    chk("t2_busy", busy, 1);
    chk("t2_sel", sel, 0);
    chk("t2_d0_valid", m_valid, 1);
    chk("t2_d0", m_data, 64'h0);
    chk("t2_d0_last", m_last, 0);
    cycle(); #1;
    chk("t2_d1", m_data, 64'h1);
    chk("t2_d1_last", m_last, 0);
    en[0] = 1'b0;
    cycle(); #1;
    chk("t2_d2", m_data, 64'h2);
    chk("t2_d2_last", m_last, 1);
    cycle(); #1;
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_m_valid", m_valid, 0);
    drain();

    // Contention, 2-beat packets; s0 went last so history favours s1 first
    set_len(2);
    en[0] = 1'b1; en[1] = 1'b1;
    out_src_q.delete(); out_cyc_q.delete();
    for (int i = 0; i < 13; i++) cycle();
    if (out_src_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), out_src_q[i], exp_order[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("t3_spacing%0d", i), out_cyc_q[i] - out_cyc_q[i-1], 3);
    end else chk("t3_pkt_count", out_src_q.size(), 4);
    drain();

    // Backpressure and a 2-cycle valid gap inside a source-1 packet
    set_len(4);
    en[1] = 1'b1; nb = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) en[1] = 1'b0;
      pv[1] = pv1_pat[k]; pr = pr_pat[k];
      cycle(); #1;
      if (k == 0) begin
        chk("t4_arb_ena0", arb_ena, 1);
        chk("t4_busy0", busy, 0);
      end else if (k < 9) begin
        chk($sformatf("t4_busy%0d", k), busy, 1);
        chk($sformatf("t4_sel%0d", k), sel, 1);
        chk($sformatf("t4_no_ena%0d", k), arb_ena, 0);
      end else chk("t4_idle", busy, 0);
      if (m_valid && m_ready) begin
        chk($sformatf("t4_beat%0d", nb), m_data[31:0], nb);
        chk($sformatf("t4_src%0d", nb), m_data[63:56], 1);
        nb++;
      end
    end
    chk("t4_beats", nb, 4);
    drain();

    // Reset in the middle of a 4-beat source-0 packet
    set_len(4);
    en[0] = 1'b1;
    cycle(); cycle(); cycle();
    #1 sys_rst = 1'b1;
    #1;
    chk("t5_m_valid_async", m_valid, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_ready_async", s0_ready, 0);
    cycle();
    sys_rst = 1'b0;
    #1;
    chk("t5_idle_after", busy, 0);
    chk("t5_arb_ena_after", arb_ena, 1);
    cycle(); #1;
    chk("t5_rearb_busy", busy, 1);
    chk("t5_rearb_sel", sel, 0);
    chk("t5_resume_beat", m_data[31:0], 1);
    drain();

    // Randomized traffic
    len_min = 1; len_max = 4;
    en[0] = 1'b1; en[1] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        pv[0] = $urandom_range(20, 100);
        pv[1] = $urandom_range(20, 100);
        pr    = $urandom_range(20, 100);
      end
      cycle();
    end
    drain();

`ifdef TX_PKT_ARB_STATS_EN
    // Counter wrap: 15 single-beat source-0 packets, then one more
    cycle();
    sys_rst = 1'b1;
    cycle();
    sys_rst = 1'b0;
    set_len(1);
    en[0] = 1'b1;
    for (int i = 0; i < 80 && pkt_cnt0 != 4'd15; i++) cycle();
    chk("t7_cnt0_15", pkt_cnt0, 15);
    chk("t7_cnt1_hold", pkt_cnt1, 0);
    for (int i = 0; i < 6 && pkt_cnt0 == 4'd15; i++) cycle();
    chk("t7_cnt0_wrap", pkt_cnt0, 0);
    chk("t7_cnt1_still", pkt_cnt1, 0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
